// File: rtl/falu_issue_seq.sv
//==============================================================================
// Module      : falu_issue_seq
// Description : Issue/collect sequencer wrapped around floating_ALU_TOP.
//               Accepts one FP op over valid/ready, drives ALU_FUNC/A/B/C
//               for the op's fixed latency, then captures the matching FALU
//               result slot and presents it with its tag over valid/ready.
//               ALU_FUNC sits at NOP_FUNC whenever no op is executing.
// Options     : `define FALU_ISSUE_BYPASS_EN lets a result handoff and a new
//               acceptance share one edge (no IDLE bubble between ops).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module falu_issue_seq #(
    parameter int           W        = 32,
    parameter int           TAG_W    = 5,
    parameter int           LAT_FMA  = 3,
    parameter int           LAT_ADD  = 2,
    parameter int           LAT_MUL  = 2,
    parameter int           LAT_DIV  = 8,
    parameter int           LAT_SQRT = 8,
    parameter int           LAT_MISC = 1,
    parameter logic [4:0]   NOP_FUNC = 5'h1F
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          in_func,
    input  logic [W-1:0]        in_a,
    input  logic [W-1:0]        in_b,
    input  logic [W-1:0]        in_c,
    input  logic [TAG_W-1:0]    in_tag,
    output logic [4:0]          ALU_FUNC,
    output logic [W-1:0]        A,
    output logic [W-1:0]        B,
    output logic [W-1:0]        C,
    input  logic [32*W-1:0]     res_bus,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*W-1:0]      out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_illegal
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [4:0]         func_q;
    logic               accept;
    logic               new_illegal;
    logic [2*W-1:0]     slot [16];

    // Latency minus one, so the counter reaches zero on the final EXEC cycle.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [4:0] f);
        int l;
        if (f <= 5'd3)       l = LAT_FMA;
        else if (f <= 5'd5)  l = LAT_ADD;
        else if (f == 5'd6)  l = LAT_MUL;
        else if (f == 5'd7)  l = LAT_DIV;
        else if (f == 5'd8)  l = LAT_SQRT;
        else                 l = LAT_MISC;
        return CNT_W'(l - 1);
    endfunction

    // Split the flat FALU result bus into per-function slots.
    for (genvar k = 0; k < 16; k++) begin : g_slot
        assign slot[k] = res_bus[k*2*W +: 2*W];
    end

`ifdef FALU_ISSUE_BYPASS_EN
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept      = in_valid && in_ready;
    assign new_illegal = in_func[4];
    assign out_valid   = (state == DONE);
    assign ALU_FUNC    = (state == EXEC) ? func_q : NOP_FUNC;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: illegal ops skip execution and go straight to the result.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) state_n = new_illegal ? DONE : EXEC;
            end
            EXEC: begin
                if (cnt == '0) state_n = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) state_n = new_illegal ? DONE : EXEC;
                    else        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand/tag latching, latency countdown and result capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            func_q      <= '0;
            cnt         <= '0;
            A           <= '0;
            B           <= '0;
            C           <= '0;
            out_data    <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            func_q      <= in_func;
            cnt         <= lat_m1(in_func);
            A           <= in_a;
            B           <= in_b;
            C           <= in_c;
            out_tag     <= in_tag;
            out_illegal <= new_illegal;
            if (new_illegal) out_data <= '0;
        end else if (state == EXEC) begin
            if (cnt == '0) out_data <= slot[func_q[3:0]];
            else           cnt      <= cnt - CNT_W'(1);
        end
    end

endmodule

`default_nettype wire
